// File: rtl/dma_write_controller.sv
// Host-write DMA engine: reads AXI bursts into a beat FIFO and replays them as
// PCIe memory-write TLPs, chunked so no chunk crosses MPS or a 4KB page.
module dma_write_controller #(
  parameter int unsigned p_fifo_bits = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [15:0]   pcie_dcommand,
  input  logic [31:0]   dma_write_host_address,
  input  logic [31:0]   dma_write_device_address,
  input  logic [31:0]   dma_write_length,
  input  logic          dma_write_start,
  output logic          busy,
  output logic          dma_write_error,
  output logic [31:0]   araddr,
  output logic [7:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  output logic [3:0]    arcache,
  output logic [2:0]    arprot,
  output logic          arvalid,
  input  logic          arready,
  input  logic [127:0]  rdata,
  input  logic [1:0]    rresp,
  input  logic          rlast,
  input  logic          rvalid,
  output logic          rready,
  output logic [31:0]   dma_write_addr,
  output logic [9:0]    dma_write_len,
  output logic          dma_write_valid,
  input  logic          dma_write_done,
  output logic [127:0]  dma_write_data,
  output logic          dma_write_data_valid,
  input  logic          dma_write_data_ready,
  output logic          int_valid,
  input  logic          int_done
);
  localparam int unsigned fifo_depth = 1 << p_fifo_bits;
  localparam int unsigned ptr_w      = p_fifo_bits + 1;

  typedef enum logic [2:0] {IDLE, AR, FILL, HDR, DATA, NEXT, INT} state_t;

  state_t            state, state_next;
  logic [31:0]       host_addr, dev_addr, remaining, chunk;
  logic [9:0]        mps, mps_dec;
  logic [127:0]      fifo_mem [fifo_depth];
  logic [ptr_w-1:0]  wr_ptr, rd_ptr;
  logic              fifo_empty, push, pop, pop_last;
  logic              unused_cfg;

  assign unused_cfg = ^{pcie_dcommand[15:8], pcie_dcommand[4:0]};

  assign arsize  = 3'b100;
  assign arburst = 2'b01;
  assign arcache = 4'b0011;
  assign arprot  = 3'b000;

  always_comb begin
    case (pcie_dcommand[7:5])
      3'b000:  mps_dec = 10'd128;
      3'b001:  mps_dec = 10'd256;
      default: mps_dec = 10'd512;
    endcase
  end

  // Largest chunk bounded by length, MPS and the 4KB page on both sides.
  always_comb begin
    chunk = remaining;
    if (32'(mps) < chunk) chunk = 32'(mps);
    if ((32'd4096 - 32'(host_addr[11:0])) < chunk) chunk = 32'd4096 - 32'(host_addr[11:0]);
    if ((32'd4096 - 32'(dev_addr[11:0])) < chunk) chunk = 32'd4096 - 32'(dev_addr[11:0]);
  end

  assign araddr         = dev_addr;
  assign arlen          = 8'((chunk >> 4) - 32'd1);
  assign dma_write_addr = host_addr;
  assign dma_write_len  = 10'(chunk >> 2);

  assign fifo_empty           = (wr_ptr == rd_ptr);
  assign push                 = rready && rvalid;
  assign pop                  = (state == DATA) && !fifo_empty && dma_write_data_ready;
  assign pop_last             = pop && ((rd_ptr + ptr_w'(1)) == wr_ptr);
  assign dma_write_data       = fifo_mem[rd_ptr[p_fifo_bits-1:0]];
  assign dma_write_data_valid = (state == DATA) && !fifo_empty;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (dma_write_start) state_next = (dma_write_length == 32'd0) ? INT : AR;
      AR:   if (arready) state_next = FILL;
      FILL: if (rvalid && rlast) state_next = HDR;
      HDR:  if (dma_write_done) state_next = DATA;
      DATA: if (pop_last) state_next = NEXT;
      NEXT: state_next = (remaining == chunk) ? INT : AR;
      INT:  if (int_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      host_addr       <= '0;
      dev_addr        <= '0;
      remaining       <= '0;
      mps             <= 10'd128;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      dma_write_valid <= 1'b0;
      int_valid       <= 1'b0;
      busy            <= 1'b0;
      dma_write_error <= 1'b0;
    end else begin
      state           <= state_next;
      arvalid         <= (state_next == AR);
      rready          <= (state_next == FILL);
      dma_write_valid <= (state_next == HDR);
      int_valid       <= (state_next == INT);
      busy            <= (state_next != IDLE);
      if (state == IDLE && dma_write_start) begin
        host_addr       <= dma_write_host_address;
        dev_addr        <= dma_write_device_address;
        remaining       <= dma_write_length;
        mps             <= mps_dec;
        dma_write_error <= 1'b0;
      end
      if (state == NEXT) begin
        host_addr <= host_addr + chunk;
        dev_addr  <= dev_addr + chunk;
        remaining <= remaining - chunk;
      end
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
        if (rresp != 2'b00) dma_write_error <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + ptr_w'(1);
    end
  end

  // Beat storage needs no reset; the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr[p_fifo_bits-1:0]] <= rdata;
  end
endmodule

// File: tb/tb_dma_write_controller.sv
// Bench for dma_write_controller: table of directed transfers, random stalls
// and random transfers checked against a chunk-list reference model.
module tb_dma_write_controller;
  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [15:0]   pcie_dcommand = '0;
  logic [31:0]   dma_write_host_address = '0, dma_write_device_address = '0, dma_write_length = '0;
  logic          dma_write_start = 1'b0;
  logic          busy, dma_write_error;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst;
  logic [3:0]    arcache;
  logic          arvalid, arready = 1'b0;
  logic [127:0]  rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0, rvalid = 1'b0, rready;
  logic [31:0]   dma_write_addr;
  logic [9:0]    dma_write_len;
  logic          dma_write_valid, dma_write_done = 1'b0;
  logic [127:0]  dma_write_data;
  logic          dma_write_data_valid, dma_write_data_ready = 1'b0;
  logic          int_valid, int_done = 1'b0;

  always #5 i_clk = ~i_clk;

  dma_write_controller #(.p_fifo_bits(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .pcie_dcommand(pcie_dcommand),
    .dma_write_host_address(dma_write_host_address),
    .dma_write_device_address(dma_write_device_address),
    .dma_write_length(dma_write_length), .dma_write_start(dma_write_start),
    .busy(busy), .dma_write_error(dma_write_error),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dma_write_addr(dma_write_addr), .dma_write_len(dma_write_len),
    .dma_write_valid(dma_write_valid), .dma_write_done(dma_write_done),
    .dma_write_data(dma_write_data), .dma_write_data_valid(dma_write_data_valid),
    .dma_write_data_ready(dma_write_data_ready),
    .int_valid(int_valid), .int_done(int_done)
  );

  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_rec_t;
  typedef struct {logic [31:0] addr; logic [9:0] len;} hdr_rec_t;
  typedef struct {logic [127:0] data; int hdr_seen;} beat_rec_t;
  typedef struct {
    logic [31:0] host, dev, len; logic [2:0] code; int eb;
    int n_chunk; logic [7:0] arlen0; logic [9:0] wlen0; logic [31:0] hlast; bit err;
  } vec_t;

  ar_rec_t   ar_q[$];
  hdr_rec_t  hdr_q[$];
  beat_rec_t beat_q[$];
  int int_count = 0, beat_idx = 0, err_beat = -1;
  int ar_stall = 0, r_stall = 0, hdr_stall = 0, int_stall = 0, r_left = 0;
  bit r_hold = 1'b0;
  logic [31:0] r_addr = '0, salt = '0;
  int n_checks = 0, n_fail = 0;
  vec_t vecs[9];

  function automatic logic [127:0] src(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a + salt, ~a, a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stalling AXI slave, PCIe sink and interrupt acknowledger; decisions made at negedge.
  always @(negedge i_clk) begin
    if (i_rst) begin
      arready = 0; rvalid = 0; rlast = 0; rresp = 0; r_left = 0; r_hold = 0;
      dma_write_done = 0; dma_write_data_ready = 0; int_done = 0;
    end else begin
      rvalid = 0; rlast = 0;
      if (r_left > 0) begin
        if (r_stall > 0 && !r_hold) r_stall--;
        else begin
          rvalid = 1; rdata = src(r_addr); rlast = (r_left == 1);
          rresp = (beat_idx == err_beat) ? 2'b10 : 2'b00;
          if (rready) begin
            r_left--; r_addr += 32'd16; beat_idx++; r_hold = 0;
            r_stall = int'($urandom_range(0, 5));
          end else r_hold = 1;
        end
      end
      arready = 0;
      if (arvalid) begin
        if (ar_stall == 0) begin
          arready = 1; ar_q.push_back('{araddr, arlen});
          r_left = int'(arlen) + 1; r_addr = araddr;
          ar_stall = int'($urandom_range(0, 5)); r_stall = int'($urandom_range(0, 5));
        end else ar_stall--;
      end
      dma_write_done = 0;
      if (dma_write_valid) begin
        if (hdr_stall == 0) begin
          dma_write_done = 1; hdr_q.push_back('{dma_write_addr, dma_write_len});
          hdr_stall = int'($urandom_range(0, 5));
        end else hdr_stall--;
      end
      dma_write_data_ready = ($urandom_range(0, 2) != 0);
      if (dma_write_data_ready && dma_write_data_valid)
        beat_q.push_back('{dma_write_data, hdr_q.size()});
      int_done = 0;
      if (int_valid) begin
        if (int_stall == 0) begin
          int_done = 1; int_count++; int_stall = int'($urandom_range(0, 3));
        end else int_stall--;
      end
    end
  end

  task automatic clear_records(input int eb);
    ar_q.delete(); hdr_q.delete(); beat_q.delete();
    int_count = 0; beat_idx = 0; err_beat = eb; salt = $urandom;
  endtask

  task automatic start_xfer(input logic [31:0] h, d, len, input logic [2:0] code);
    @(negedge i_clk);
    dma_write_host_address = h; dma_write_device_address = d; dma_write_length = len;
    pcie_dcommand = {8'h00, code, 5'h00}; dma_write_start = 1'b1;
    @(negedge i_clk);
    dma_write_start = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] h, d, len, input logic [2:0] code,
                          input int eb, input bit glitch);
    ar_rec_t exp_ar[$];
    hdr_rec_t exp_hdr[$];
    logic [127:0] exp_beats[$];
    int exp_chunk[$];
    int unsigned m, c;
    logic [31:0] hh, dd, rem;
    int ci;
    m = (code == 3'd0) ? 128 : (code == 3'd1) ? 256 : 512;
    hh = h; dd = d; rem = len; ci = 0;
    clear_records(eb);
    while (rem != 0) begin
      c = rem;
      if (m < c) c = m;
      if (4096 - (hh % 4096) < c) c = 4096 - (hh % 4096);
      if (4096 - (dd % 4096) < c) c = 4096 - (dd % 4096);
      exp_ar.push_back('{dd, 8'(c / 16 - 1)});
      exp_hdr.push_back('{hh, 10'(c / 4)});
      for (int k = 0; k < int'(c / 16); k++) begin
        exp_beats.push_back(src(dd + 32'(16 * k)));
        exp_chunk.push_back(ci);
      end
      hh += c; dd += c; rem -= c; ci++;
    end
    start_xfer(h, d, len, code);
    check("busy_after_start", 128'(busy), 128'(1));
    check("arvalid_after_start", 128'(arvalid), 128'(len != 0));
    check("int_valid_after_start", 128'(int_valid), 128'(len == 0));
    check("error_cleared_on_start", 128'(dma_write_error), 128'(0));
    if (glitch) begin
      dma_write_host_address = ~h; dma_write_length = len + 32'd16;
      pcie_dcommand = 16'h0000; dma_write_start = 1'b1;
      @(negedge i_clk);
      dma_write_start = 1'b0;
    end
    for (int cyc = 0; cyc < 20000 && int_count == 0; cyc++) @(negedge i_clk);
    repeat (2) @(negedge i_clk);
    check("int_count", 128'(int_count), 128'(1));
    check("int_valid_dropped", 128'(int_valid), 128'(0));
    check("busy_after_done", 128'(busy), 128'(0));
    check("n_ar", 128'(ar_q.size()), 128'(exp_ar.size()));
    check("n_hdr", 128'(hdr_q.size()), 128'(exp_hdr.size()));
    check("n_beats", 128'(beat_q.size()), 128'(exp_beats.size()));
    for (int i = 0; i < ar_q.size() && i < exp_ar.size(); i++) begin
      check("araddr", 128'(ar_q[i].addr), 128'(exp_ar[i].addr));
      check("arlen", 128'(ar_q[i].len), 128'(exp_ar[i].len));
    end
    for (int i = 0; i < hdr_q.size() && i < exp_hdr.size(); i++) begin
      check("hdr_addr", 128'(hdr_q[i].addr), 128'(exp_hdr[i].addr));
      check("hdr_len", 128'(hdr_q[i].len), 128'(exp_hdr[i].len));
    end
    for (int i = 0; i < beat_q.size() && i < exp_beats.size(); i++) begin
      check("payload", beat_q[i].data, exp_beats[i]);
      check("hdr_before_data", 128'(beat_q[i].hdr_seen > exp_chunk[i]), 128'(1));
    end
    check("error_flag", 128'(dma_write_error), 128'(eb >= 0 && eb < exp_beats.size()));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, d, len;
    int eb;
    vecs[0] = '{32'h0000_1000, 32'h0000_0000, 32'd64,   3'd0,  -1, 1, 8'd3,  10'd16,  32'h0000_1000, 1'b0};
    vecs[1] = '{32'h0000_1000, 32'h0000_4000, 32'd1024, 3'd1,  -1, 4, 8'd15, 10'd64,  32'h0000_1300, 1'b0};
    vecs[2] = '{32'h0000_0FC0, 32'h0000_2000, 32'd128,  3'd2,  -1, 2, 8'd3,  10'd16,  32'h0000_1000, 1'b0};
    vecs[3] = '{32'h0000_2000, 32'h0000_0FE0, 32'd128,  3'd2,  -1, 2, 8'd1,  10'd8,   32'h0000_2020, 1'b0};
    vecs[4] = '{32'h0000_3000, 32'h0000_5000, 32'd64,   3'd0,   1, 1, 8'd3,  10'd16,  32'h0000_3000, 1'b1};
    vecs[5] = '{32'h0000_3000, 32'h0000_5000, 32'd64,   3'd0,  -1, 1, 8'd3,  10'd16,  32'h0000_3000, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 32'd2048, 3'd7,  -1, 4, 8'd31, 10'd128, 32'h0000_0600, 1'b0};
    vecs[7] = '{32'hFFFF_FF00, 32'h0000_0100, 32'd512,  3'd2,  -1, 2, 8'd15, 10'd64,  32'h0000_0000, 1'b0};
    vecs[8] = '{32'h0000_5000, 32'h0000_6000, 32'd0,    3'd0,  -1, 0, 8'd0,  10'd0,   32'h0000_0000, 1'b0};

    repeat (3) @(negedge i_clk);
    check("rst_arvalid", 128'(arvalid), 128'(0));
    check("rst_rready", 128'(rready), 128'(0));
    check("rst_hdr_valid", 128'(dma_write_valid), 128'(0));
    check("rst_data_valid", 128'(dma_write_data_valid), 128'(0));
    check("rst_int_valid", 128'(int_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_error", 128'(dma_write_error), 128'(0));
    check("arsize", 128'(arsize), 128'(3'b100));
    check("arburst", 128'(arburst), 128'(2'b01));
    check("arcache", 128'(arcache), 128'(4'b0011));
    check("arprot", 128'(arprot), 128'(3'b000));
    i_rst = 1'b0;
    @(negedge i_clk);

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i].host, vecs[i].dev, vecs[i].len, vecs[i].code, vecs[i].eb, vecs[i].len >= 256);
      check("vec_n_chunk", 128'(ar_q.size()), 128'(vecs[i].n_chunk));
      check("vec_error", 128'(dma_write_error), 128'(vecs[i].err));
      if (vecs[i].n_chunk > 0 && hdr_q.size() > 0 && ar_q.size() > 0) begin
        check("vec_arlen0", 128'(ar_q[0].len), 128'(vecs[i].arlen0));
        check("vec_wlen0", 128'(hdr_q[0].len), 128'(vecs[i].wlen0));
        check("vec_host_last", 128'(hdr_q[hdr_q.size()-1].addr), 128'(vecs[i].hlast));
      end
    end

    // Reset pulsed while payload is draining abandons the transfer silently.
    clear_records(0);
    start_xfer(32'h0000_1000, 32'h0000_0000, 32'd256, 3'd1);
    for (int cyc = 0; cyc < 5000 && beat_q.size() < 2; cyc++) @(negedge i_clk);
    check("reached_data", 128'(beat_q.size() >= 2), 128'(1));
    check("err_before_rst", 128'(dma_write_error), 128'(1));
    i_rst = 1'b1;
    @(negedge i_clk);
    check("mid_rst_arvalid", 128'(arvalid), 128'(0));
    check("mid_rst_rready", 128'(rready), 128'(0));
    check("mid_rst_hdr_valid", 128'(dma_write_valid), 128'(0));
    check("mid_rst_data_valid", 128'(dma_write_data_valid), 128'(0));
    check("mid_rst_int_valid", 128'(int_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_error", 128'(dma_write_error), 128'(0));
    @(negedge i_clk);
    i_rst = 1'b0;
    int_count = 0;
    repeat (50) @(negedge i_clk);
    check("no_int_after_rst", 128'(int_count), 128'(0));
    check("idle_after_rst", 128'(busy), 128'(0));
    run_xfer(32'h0000_8000, 32'h0001_0000, 32'd320, 3'd1, -1, 1'b0);

    for (int t = 0; t < 16; t++) begin
      h = ($urandom & 32'hFFFF_F000) | ((32'd4096 - 32'(16 * $urandom_range(1, 48))) & 32'h0000_0FF0);
      d = ($urandom & 32'hFFFF_F000) | ((32'd4096 - 32'(16 * $urandom_range(1, 48))) & 32'h0000_0FF0);
      len = 32'(16 * $urandom_range(0, 80));
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_xfer(h, d, len, 3'($urandom_range(0, 7)), eb, (len != 0) && ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_write_controller.md
DMA_WRITE_CONTROLLER -- requirements
Module: dma_write_controller

Interface
REQ-001 The module SHALL have parameter p_fifo_bits, default 6, meaning log2 of the data FIFO depth in 128-bit beats; the minimum legal value is 5.
REQ-002 The module SHALL have the following clock and reset ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  reset, synchronous and active-high.
REQ-003 The module SHALL have the following configuration ports:
- pcie_dcommand  in  16  PCIe device control; bits [7:5] give the max payload size (MPS).
- dma_write_host_address  in  32  host destination byte address, 16B-aligned.
- dma_write_device_address  in  32  AXI source byte address, 16B-aligned.
- dma_write_length  in  32  transfer byte count, a multiple of 16.
- dma_write_start  in  1  one-cycle start pulse.
- busy  out  1  high while a transfer is active.
- dma_write_error  out  1  sticky flag, set on any non-OKAY rresp.
REQ-004 The module SHALL have the following AXI read ports:
- araddr 32, arlen 8, arsize 3, arburst 2, arcache 4, arprot 3, arvalid 1: all outputs.
- arready 1: input.
- rdata 128, rresp 2, rlast 1, rvalid 1: all inputs.
- rready 1: output.
REQ-005 The module SHALL have the following PCIe write-request ports:
- dma_write_addr  out  32  TLP host address.
- dma_write_len  out  10  TLP length in DWORDs.
- dma_write_valid  out  1  header request.
- dma_write_done  in  1  header accepted, one-cycle pulse.
- dma_write_data  out  128  payload beat.
- dma_write_data_valid  out  1  payload beat valid.
- dma_write_data_ready  in  1  payload beat accepted.
REQ-006 The module SHALL have the following interrupt ports:
- int_valid  out  1  completion interrupt request.
- int_done  in  1  interrupt acknowledge.

Function
REQ-007 Constant AXI outputs SHALL be: arsize=3'b100, arburst=2'b01 (INCR), arcache=4'b0011, arprot=3'b000.
REQ-008 MPS SHALL be decoded from pcie_dcommand[7:5], sampled at start: 000 gives 128B, 001 gives 256B, any other value clamps to 512B.
REQ-009 Chunk size SHALL be min(remaining, MPS, 4096-host_addr[11:0], 4096-dev_addr[11:0]); this guarantees no 4KB crossing on either side.
REQ-010 Per chunk, the block SHALL drive arlen=chunk/16-1 and dma_write_len=chunk/4 (10 bits, never 0), with araddr=dev_addr and dma_write_addr=host_addr.
REQ-011 The FSM SHALL have states IDLE, AR, FILL, HDR, DATA, NEXT and INT.
REQ-012 In IDLE, when dma_write_start is high, the block SHALL latch the addresses, length and MPS, clear dma_write_error, and go to AR; if the length is 0 it SHALL go to INT instead.
REQ-013 In AR, arvalid SHALL be high with stable araddr/arlen; on arready the FSM SHALL go to FILL.
REQ-014 The first arvalid SHALL assert in the cycle after dma_write_start is sampled.
REQ-015 In FILL, rready SHALL be high; each rvalid beat SHALL be written to the FIFO; the beat with rlast SHALL move the FSM to HDR.
REQ-016 A beat count that disagrees with arlen at rlast SHALL be undefined (not checked).
REQ-017 In HDR, dma_write_valid SHALL be high; on dma_write_done the FSM SHALL go to DATA.
REQ-018 In DATA, dma_write_data_valid SHALL equal FIFO not-empty, and dma_write_data SHALL be the FIFO head.
REQ-019 Each cycle in DATA with valid and dma_write_data_ready both high SHALL pop one beat; popping the last beat of the chunk SHALL move the FSM to NEXT.
REQ-020 Outside DATA, dma_write_data_valid SHALL be 0.
REQ-021 NEXT SHALL last one cycle: host_addr+=chunk, dev_addr+=chunk, remaining-=chunk (32-bit arithmetic); if remaining becomes 0 the FSM SHALL go to INT, otherwise to AR.
REQ-022 In INT, int_valid SHALL be high until int_done; int_done SHALL return the FSM to IDLE with int_valid low in the following cycle.
REQ-023 A non-OKAY rresp on any beat SHALL set dma_write_error; the data SHALL still be forwarded and the transfer SHALL continue.
REQ-024 dma_write_start while busy SHALL be ignored, with no relatch.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Host-address wrap past 2^32 SHALL wrap modulo 2^32, with no error.
REQ-027 The FIFO SHALL never overflow, since max chunk (32 beats) ≤ depth; the FIFO SHALL be empty on entry to AR.

Reset
REQ-028 i_rst SHALL force the FSM to IDLE, flush the FIFO, and clear remaining.
REQ-029 Under i_rst, all outputs SHALL go to 0 in the next cycle: arvalid, rready, dma_write_valid, dma_write_data_valid, int_valid, busy and dma_write_error.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer, including any outstanding AXI burst, with no interrupt raised.
REQ-031 After reset, the first accepted start SHALL behave as from power-up.

Verification
REQ-032 host=0x1000, dev=0x0, len=64, MPS code 000: the bench SHALL see 1 chunk with arlen=3 and dma_write_len=16, 4 data beats in order, then int_valid.
REQ-033 len=1024, MPS code 001, aligned addresses: the bench SHALL see 4 chunks of 256B (arlen=15, dma_write_len=64) with host addresses 0x1000, 0x1100, 0x1200, 0x1300.
REQ-034 host=0x0FC0, dev=0x2000, len=128, MPS code 010: the bench SHALL see chunks of 64B then 64B, split at the host 4KB boundary; dev=0x0FE0 SHALL give 32B then 96B.
REQ-035 With random arready/rvalid/dma_write_data_ready stalls (0-5 cycles) and dma_write_done delays, the payload SHALL match the AXI source byte-exact and each header SHALL precede its data.
REQ-036 rresp=2'b10 on beat 2 of 4 SHALL set dma_write_error=1, the transfer SHALL still complete with int_valid, and the next start SHALL clear the error.
REQ-037 len=0 SHALL give int_valid within 2 cycles with no arvalid; i_rst pulsed during DATA SHALL clear all outputs to 0 and no int_valid SHALL follow.
